chip_axil_reg_responder: RTL
============================

// Module: chip_axil_reg_responder
// PURPOSE
//  AXI4-Lite slave (responder) register file for the chip test environment.
//  Terminates transactions issued by the AXI4-Lite master VIP or the PS.
//  Exposes NUM_REGS 32-bit read/write registers to downstream chip-control logic,
//  with a per-register write strobe.
//  Completes AW/W/B and AR/R handshakes with OKAY or SLVERR responses.
// PARAMETERS
//  NUM_REGS   4   number of 32-bit registers, at byte addresses 0x0, 0x4, ...
//  ADDR_W     5   AXI address width; index = addr[ADDR_W-1:2]
//  RESET_VAL  0   value loaded into every register on reset
// PORTS
//  s00_axi_aclk     in   1            single clock; all logic on its rising edge
//  s00_axi_areset   in   1            synchronous, active-high reset
//  s00_axi_awaddr   in   ADDR_W       write address
//  s00_axi_awprot   in   3            ignored
//  s00_axi_awvalid  in   1            write address valid
//  s00_axi_awready  out  1            write address ready
//  s00_axi_wdata    in   32           write data
//  s00_axi_wstrb    in   4            byte enables; bit n enables byte n
//  s00_axi_wvalid   in   1            write data valid
//  s00_axi_wready   out  1            write data ready
//  s00_axi_bresp    out  2            write response: 00=OKAY, 10=SLVERR
//  s00_axi_bvalid   out  1            write response valid
//  s00_axi_bready   in   1            write response ready
//  s00_axi_araddr   in   ADDR_W       read address
//  s00_axi_arprot   in   3            ignored
//  s00_axi_arvalid  in   1            read address valid
//  s00_axi_arready  out  1            read address ready
//  s00_axi_rdata    out  32           read data
//  s00_axi_rresp    out  2            read response: 00=OKAY, 10=SLVERR
//  s00_axi_rvalid   out  1            read data valid
//  s00_axi_rready   in   1            read data ready
//  reg_out          out  NUM_REGS*32  register contents; reg k at bits [32k+31:32k]
//  reg_wr_strobe    out  NUM_REGS     1-cycle pulse, one bit per register written
// BEHAVIOUR
//  Reset (while areset=1):
//   - all ready/valid outputs = 0; bresp = rresp = 00; rdata = 0
//   - every register = RESET_VAL; reg_wr_strobe = 0
//   - first cycle after release: awready = wready = arready = 1
//   - reset mid-transaction drops any pending B/R; FSMs return to IDLE
//  Write FSM: W_IDLE -> W_GOT_AW | W_GOT_W | W_RESP; W_GOT_* -> W_RESP; W_RESP -> W_IDLE
//   - awready = 1 in W_IDLE, W_GOT_W; wready = 1 in W_IDLE, W_GOT_AW
//   - AW and W may arrive in either order or in the same cycle; address and data latched
//   - commit on the edge where the second of the two handshakes completes
//   - bvalid asserts the next cycle and holds until bvalid & bready
//   - no new AW/W is accepted in W_RESP
//   - reg_wr_strobe[k] pulses in the cycle after commit, aligned with bvalid rising
//   - WSTRB merge: byte n updated only if wstrb[n]; wstrb = 0000 -> OKAY, no change, strobe still pulses
//  Read FSM: R_IDLE (arready=1) -> R_DATA (rvalid=1) on AR handshake; R_DATA -> R_IDLE on rready
//   - rdata and rresp captured at the AR handshake edge and held stable while rvalid=1
//   - maximum rate: one read per 2 cycles
//  Decode: addr[1:0] ignored; index >= NUM_REGS -> SLVERR
//   - out-of-range write is discarded, with no strobe
//   - out-of-range read returns rdata = 0
//  Simultaneous read and write of the same register on one edge: read returns the
//   pre-write value. The read and write channels are otherwise fully independent.
// STRUCTURE
//  chip_axil_pkg:
//   - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, C_DATA_W = 32
//   - wr_state_t and rd_state_t enums
//  Single module; no sub-module (both FSMs are small, the register array is inline).
// TESTING  (NUM_REGS=4, ADDR_W=5)
//  1 Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read the same addresses
//     -> rdata 1,2,3,4; all bresp/rresp = OKAY.
//  2 reg1 = 0x00000002; W (0xAABBCCDD, wstrb 0101) presented 3 cycles before AW
//     -> reg1 = 0x00BB00DD; reg_wr_strobe = 0010 for one cycle.
//  3 Write 0x10 to 0x10, then read 0x10
//     -> bresp = SLVERR with all registers unchanged; rresp = SLVERR, rdata = 0.
//  4 bready held low 10 cycles after a write
//     -> bvalid stays 1, awready = wready = 0; next AW accepted only after the B handshake.
//  5 Write 0x55 to reg2 and read 0x8 on the same edge (old reg2 = 3)
//     -> rdata = 3; a following read of 0x8 -> 0x55.
//  6 areset pulsed while rvalid = 1 and a write is in W_GOT_AW
//     -> next cycle rvalid = bvalid = 0 and all registers = 0;
//        after release, awready = wready = arready = 1.

Source files
------------

// File: rtl/chip_axil_pkg.sv
// Shared types and constants for the AXI4-Lite register responder.
package chip_axil_pkg;

   localparam int         C_DATA_W    = 32;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write channel: waits for AW and W in either order, then holds B.
   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_GOT_AW = 2'd1,
      W_GOT_W  = 2'd2,
      W_RESP   = 2'd3
   } wr_state_t;

   // Read channel: accepts AR, then holds R until the master takes it.
   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage

// File: rtl/chip_axil_reg_responder.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit read/write registers with a
// per-register one-cycle write strobe. Out-of-range accesses get SLVERR.
module chip_axil_reg_responder
   import chip_axil_pkg::*;
#(
   parameter int                  NUM_REGS  = 4,
   parameter int                  ADDR_W    = 5,
   parameter logic [C_DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         s00_axi_aclk,
   input  logic                         s00_axi_areset,
   input  logic [ADDR_W-1:0]            s00_axi_awaddr,
   input  logic [2:0]                   s00_axi_awprot,
   input  logic                         s00_axi_awvalid,
   output logic                         s00_axi_awready,
   input  logic [C_DATA_W-1:0]          s00_axi_wdata,
   input  logic [3:0]                   s00_axi_wstrb,
   input  logic                         s00_axi_wvalid,
   output logic                         s00_axi_wready,
   output logic [1:0]                   s00_axi_bresp,
   output logic                         s00_axi_bvalid,
   input  logic                         s00_axi_bready,
   input  logic [ADDR_W-1:0]            s00_axi_araddr,
   input  logic [2:0]                   s00_axi_arprot,
   input  logic                         s00_axi_arvalid,
   output logic                         s00_axi_arready,
   output logic [C_DATA_W-1:0]          s00_axi_rdata,
   output logic [1:0]                   s00_axi_rresp,
   output logic                         s00_axi_rvalid,
   input  logic                         s00_axi_rready,
   output logic [NUM_REGS*C_DATA_W-1:0] reg_out,
   output logic [NUM_REGS-1:0]          reg_wr_strobe
);

   // Word index width: the two byte-offset bits are dropped.
   localparam int IDX_W = ADDR_W - 2;

   wr_state_t             wr_state_q, wr_state_d;
   logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
   logic [C_DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [NUM_REGS-1:0]   wr_strobe_q, wr_strobe_d;
   logic [C_DATA_W-1:0]   reg_q [NUM_REGS];
   logic [C_DATA_W-1:0]   reg_d [NUM_REGS];

   rd_state_t             rd_state_q, rd_state_d;
   logic [C_DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  wr_commit;
   logic [IDX_W-1:0]      rd_idx;
   logic                  unused_inputs;

   // Protection bits and byte offsets carry no meaning for this register file.
   assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                            s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // Handshake outputs are forced low while reset is asserted.
   assign s00_axi_awready = ~s00_axi_areset &
                            ((wr_state_q == W_IDLE) || (wr_state_q == W_GOT_W));
   assign s00_axi_wready  = ~s00_axi_areset &
                            ((wr_state_q == W_IDLE) || (wr_state_q == W_GOT_AW));
   assign s00_axi_bvalid  = ~s00_axi_areset & (wr_state_q == W_RESP);
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_arready = ~s00_axi_areset & (rd_state_q == R_IDLE);
   assign s00_axi_rvalid  = ~s00_axi_areset & (rd_state_q == R_DATA);
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = rresp_q;
   assign reg_wr_strobe   = wr_strobe_q;

   assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
   assign w_hs   = s00_axi_wvalid  & s00_axi_wready;
   assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
   assign rd_idx = s00_axi_araddr[ADDR_W-1:2];

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
         assign reg_out[C_DATA_W*gi +: C_DATA_W] = reg_q[gi];
      end
   endgenerate

   // Write FSM: latch AW/W as they arrive, commit with byte merge once both are in.
   always_comb begin
      wr_state_d  = wr_state_q;
      wr_idx_d    = wr_idx_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      bresp_d     = bresp_q;
      wr_strobe_d = '0;
      reg_d       = reg_q;
      wr_commit   = 1'b0;

      if (aw_hs) begin
         wr_idx_d = s00_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
         wdata_d = s00_axi_wdata;
         wstrb_d = s00_axi_wstrb;
      end

      case (wr_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_commit = 1'b1;
            end else if (aw_hs) begin
               wr_state_d = W_GOT_AW;
            end else if (w_hs) begin
               wr_state_d = W_GOT_W;
            end
         end
         W_GOT_AW: begin
            if (w_hs) begin
               wr_commit = 1'b1;
            end
         end
         W_GOT_W: begin
            if (aw_hs) begin
               wr_commit = 1'b1;
            end
         end
         W_RESP: begin
            if (s00_axi_bready) begin
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase

      // The _d copies already hold whichever of address/data arrived this cycle.
      if (wr_commit) begin
         wr_state_d = W_RESP;
         bresp_d    = RESP_SLVERR;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_idx_d == IDX_W'(k)) begin
               bresp_d        = RESP_OKAY;
               wr_strobe_d[k] = 1'b1;
               for (int b = 0; b < 4; b++) begin
                  if (wstrb_d[b]) begin
                     reg_d[k][8*b +: 8] = wdata_d[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Read FSM: capture data from the pre-write register contents at AR handshake.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;

      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rd_state_d = R_DATA;
               rdata_d    = '0;
               rresp_d    = RESP_SLVERR;
               for (int k = 0; k < NUM_REGS; k++) begin
                  if (rd_idx == IDX_W'(k)) begin
                     rdata_d = reg_q[k];
                     rresp_d = RESP_OKAY;
                  end
               end
            end
         end
         R_DATA: begin
            if (s00_axi_rready) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Write-side state, latched request, response and register array.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         wr_state_q  <= W_IDLE;
         wr_idx_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         bresp_q     <= RESP_OKAY;
         wr_strobe_q <= '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            reg_q[k] <= RESET_VAL;
         end
      end else begin
         wr_state_q  <= wr_state_d;
         wr_idx_q    <= wr_idx_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         bresp_q     <= bresp_d;
         wr_strobe_q <= wr_strobe_d;
         reg_q       <= reg_d;
      end
   end

   // Read-side state and held response.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

endmodule
